// File: rtl/branch_target_buffer_pkg.sv
// ---------------------------------------------------------------------------
// branch_target_buffer_pkg
// Shared definitions for the IF-stage branch target buffer:
//   - br_verdict_e : 2-bit verdict codes produced by the branch-decision unit
//   - BF_HIT/BF_PRED : bit positions inside the 2-bit branch flags bundle
//   - seq_npc()    : sequential next-PC (PC+4, wraps modulo 2^32)
// ---------------------------------------------------------------------------
package branch_target_buffer_pkg;

  localparam int PC_W = 32;

  // Verdict returned by the branch-decision unit for the branch sitting in EX.
  typedef enum logic [1:0] {
    BR_OK          = 2'b00,  // prediction was correct
    BR_MISS_TAKEN  = 2'b01,  // BTB miss, branch was taken
    BR_NT_TAKEN    = 2'b10,  // hit, predicted not-taken, actually taken
    BR_T_NOTTAKEN  = 2'b11   // predicted taken, actually not-taken
  } br_verdict_e;

  // Bit positions of BranchFlagsF / BranchFlagsE.
  localparam int BF_HIT  = 0;
  localparam int BF_PRED = 1;

  // Fall-through fetch address; the natural 32-bit overflow gives the wrap.
  function automatic logic [PC_W-1:0] seq_npc(input logic [PC_W-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/branch_target_buffer_sat_counter.sv
// ---------------------------------------------------------------------------
// btb_sat_counter
// Saturating up-counter used for the BTB statistics.
// Ports:
//   clk   - clock, counts on rising edge
//   rst_n - asynchronous active-low reset, clears the count
//   en    - increment request for this cycle
//   count - current count, sticks at all-ones instead of wrapping
// ---------------------------------------------------------------------------
module btb_sat_counter
  import branch_target_buffer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Increment only while below all-ones so the statistic never rolls over.
  always_comb begin
    count_d = count_q;
    if (en && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/branch_target_buffer.sv
// ---------------------------------------------------------------------------
// branch_target_buffer
// Direct-mapped BTB with a 1-bit taken history per entry, looked up in IF
// and trained from the branch verdict in EX. Also keeps saturating counts of
// resolved branches and of mispredictions.
// Ports:
//   clk, rst_n     - clock and asynchronous active-low reset
//   PCF            - fetch PC to look up (combinational)
//   PredictedNPCF  - predicted next fetch PC (target if predicted taken,
//                    otherwise PCF+4)
//   BranchFlagsF   - {predict taken, hit}; piped to EX by the pipeline
//   UpdateEnE      - EX holds a real, live branch this cycle
//   PCE, BrTargetE - PC and resolved target of the branch in EX
//   BranchE        - verdict from the branch-decision unit
//   BranchCnt      - branches resolved with UpdateEnE=1 (saturating)
//   MispredCnt     - of those, verdict other than BR_OK (saturating)
// ---------------------------------------------------------------------------
module branch_target_buffer
  import branch_target_buffer_pkg::*;
#(
  parameter int ENTRY_BITS = 6,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      PCF,
  output logic [31:0]      PredictedNPCF,
  output logic [1:0]       BranchFlagsF,
  input  logic             UpdateEnE,
  input  logic [31:0]      PCE,
  input  logic [31:0]      BrTargetE,
  input  logic [1:0]       BranchE,
  output logic [CNT_W-1:0] BranchCnt,
  output logic [CNT_W-1:0] MispredCnt
);

  localparam int ENTRIES = 1 << ENTRY_BITS;
  localparam int TAG_W   = 30 - ENTRY_BITS;

  // Per-entry state. valid/hist are reset; tag/target are qualified by valid.
  logic [ENTRIES-1:0] valid_q;
  logic [ENTRIES-1:0] valid_d;
  logic [ENTRIES-1:0] hist_q;
  logic [ENTRIES-1:0] hist_d;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];

  logic [ENTRY_BITS-1:0] idx_f;
  logic [ENTRY_BITS-1:0] idx_e;
  logic [TAG_W-1:0]      tag_f;
  logic [TAG_W-1:0]      tag_e;
  logic                  hit_f;
  logic                  taken_f;
  br_verdict_e           verdict_e;
  logic                  tag_we;
  logic                  target_we;
  logic                  mispred_en;
  logic                  unused_pc_lsbs;

  // Instructions are word aligned, so the two low PC bits carry no information.
  assign unused_pc_lsbs = ^{PCF[1:0], PCE[1:0]};

  assign idx_f = PCF[ENTRY_BITS+1:2];
  assign tag_f = PCF[31:ENTRY_BITS+2];
  assign idx_e = PCE[ENTRY_BITS+1:2];
  assign tag_e = PCE[31:ENTRY_BITS+2];

  // ---------------------------------------------------------------------
  // Lookup: reads the registered table only, so a write in the same cycle
  // to the same index is not visible until the following cycle.
  // ---------------------------------------------------------------------
  assign hit_f   = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
  assign taken_f = hit_f && hist_q[idx_f];

  always_comb begin
    BranchFlagsF          = '0;
    BranchFlagsF[BF_HIT]  = hit_f;
    BranchFlagsF[BF_PRED] = taken_f;
  end

  assign PredictedNPCF = taken_f ? target_q[idx_f] : seq_npc(PCF);

  // ---------------------------------------------------------------------
  // Training: the verdict already encodes what went wrong, so no tag check
  // is done here; only a miss-taken verdict (re)allocates the entry.
  // ---------------------------------------------------------------------
  assign verdict_e = br_verdict_e'(BranchE);

  always_comb begin
    valid_d   = valid_q;
    hist_d    = hist_q;
    tag_we    = 1'b0;
    target_we = 1'b0;
    if (UpdateEnE) begin
      case (verdict_e)
        BR_MISS_TAKEN: begin
          valid_d[idx_e] = 1'b1;
          hist_d[idx_e]  = 1'b1;
          tag_we         = 1'b1;
          target_we      = 1'b1;
        end
        BR_NT_TAKEN: begin
          hist_d[idx_e] = 1'b1;
          target_we     = 1'b1;
        end
        BR_T_NOTTAKEN: begin
          hist_d[idx_e] = 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  // Reset clears valid and history; an update racing with reset is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      hist_q  <= '0;
    end else begin
      valid_q <= valid_d;
      hist_q  <= hist_d;
    end
  end

  // Tag/target storage has no reset. A write landing during reset is harmless:
  // the entry stays invalid and is fully rewritten by the next allocation.
  always_ff @(posedge clk) begin
    if (tag_we) begin
      tag_q[idx_e] <= tag_e;
    end
    if (target_we) begin
      target_q[idx_e] <= BrTargetE;
    end
  end

  // ---------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------
  assign mispred_en = UpdateEnE && (verdict_e != BR_OK);

  btb_sat_counter #(
    .CNT_W (CNT_W)
  ) u_branch_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (UpdateEnE),
    .count (BranchCnt)
  );

  btb_sat_counter #(
    .CNT_W (CNT_W)
  ) u_mispred_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (mispred_en),
    .count (MispredCnt)
  );

endmodule
